// File: rtl/johnson_step_ctrl_pkg.sv
// Shared types for the Johnson step controller: FSM state encoding and step direction.
// Optional build macro JOHNSON_SELFCHECK_EN is consumed by johnson_core and johnson_step_ctrl.
package johnson_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/johnson_step_ctrl_if.sv
// Command/status bundle between a control master and the Johnson step controller.
interface johnson_step_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_dir;
    logic             abort;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             err;

    modport master (
        output cmd_valid, cmd_steps, cmd_dir, abort,
        input  cmd_ready, out, busy, done, aborted, err
    );

    modport slave (
        input  cmd_valid, cmd_steps, cmd_dir, abort,
        output cmd_ready, out, busy, done, aborted, err
    );
endinterface

// File: rtl/johnson_step_ctrl_core.sv
// WIDTH-bit Johnson register with enable, direction and synchronous clear.
// With JOHNSON_SELFCHECK_EN defined it also flags values that are not Johnson codes.
module johnson_core
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_en,
    input  logic             i_dir,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_out,
    output logic             o_illegal
);

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        if (i_dir == DIR_REV) w_next = {~r_out[0], r_out[WIDTH-1:1]};
        else                  w_next = {r_out[WIDTH-2:0], ~r_out[WIDTH-1]};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      r_out <= '0;
        else if (i_clr) r_out <= '0;
        else if (i_en)  r_out <= w_next;
    end

    assign o_out = r_out;

`ifdef JOHNSON_SELFCHECK_EN
    // A legal Johnson code has at most one 0/1 boundary between neighbouring bits.
    logic [WIDTH-2:0] w_diff;
    assign w_diff    = r_out[WIDTH-1:1] ^ r_out[WIDTH-2:0];
    assign o_illegal = ($countones(w_diff) > 1);
`else
    assign o_illegal = 1'b0;
`endif

endmodule

// File: rtl/johnson_step_ctrl.sv
// Command-driven Johnson counter sequencer: accepts (steps, dir), steps once per clock, pulses done.
// JOHNSON_SELFCHECK_EN enables the illegal-state checker and the err pulse.
module johnson_step_ctrl
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rstn,
    johnson_step_ctrl_if.slave  bus
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_remaining_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_aborted;
    logic             r_err;
    logic             w_step;
    logic             w_end;
    logic             w_end_abort;
    logic             w_illegal;
    logic [WIDTH-1:0] w_out;

    johnson_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rstn      (rstn),
        .i_en      (w_step),
        .i_dir     (r_dir),
        .i_clr     (w_illegal),
        .o_out     (w_out),
        .o_illegal (w_illegal)
    );

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_dir_nxt       = r_dir;
        w_step          = 1'b0;
        w_end           = 1'b0;
        w_end_abort     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.cmd_valid && r_ready) begin
                    w_dir_nxt = bus.cmd_dir;
                    if (bus.cmd_steps == '0) begin
                        w_state_nxt = DONE;
                        w_end       = 1'b1;
                    end else begin
                        w_remaining_nxt = bus.cmd_steps;
                        w_state_nxt     = RUN;
                    end
                end
            end
            RUN: begin
                // An illegal code or an abort ends the run without taking this cycle's step.
                if (w_illegal || bus.abort) begin
                    w_state_nxt = DONE;
                    w_end       = 1'b1;
                    w_end_abort = 1'b1;
                end else begin
                    w_step          = 1'b1;
                    w_remaining_nxt = r_remaining - 1'b1;
                    if (r_remaining == CNT_W'(1)) begin
                        w_state_nxt = DONE;
                        w_end       = 1'b1;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_dir       <= DIR_FWD;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_dir       <= w_dir_nxt;
            r_ready     <= (w_state_nxt == IDLE);
            r_busy      <= (w_state_nxt == RUN);
            r_done      <= w_end;
            r_aborted   <= w_end_abort;
            r_err       <= w_illegal;
        end
    end

    assign bus.cmd_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.aborted   = r_aborted;
    assign bus.err       = r_err;
    assign bus.out       = w_out;

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// Self-checking bench for johnson_step_ctrl: directed scenarios plus random commands vs a phase model.
module tb_johnson_step_ctrl;

    localparam int W = 4;
    localparam int C = 8;
    localparam int PERIOD = 2 * W;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pos      = 0;

    always #5 clk = ~clk;

    johnson_step_ctrl_if #(.WIDTH(W), .CNT_W(C)) bus ();

    johnson_step_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Johnson value at phase p: p ones filling from the LSB, then zeros filling from the LSB.
    function automatic logic [W-1:0] phase_val(input int p);
        int v;
        if (p < W) v = (1 << p) - 1;
        else       v = ((1 << W) - 1) << (p - W);
        return v[W-1:0];
    endfunction

    function automatic logic [W+4:0] observe();
        return {bus.out, bus.busy, bus.cmd_ready, bus.done, bus.aborted, bus.err};
    endfunction

    task automatic do_cmd(input string name, input int steps, input bit dir, input int abort_k);
        logic [W+4:0] exp;
        logic [W+4:0] obs;
        bit           ended;
        bit           exp_ab;
        n_checks++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL %s start: cmd_ready=%b want 1", name, bus.cmd_ready);
        else n_pass++;
        bus.cmd_valid = 1'b1;
        bus.cmd_steps = C'(steps);
        bus.cmd_dir   = dir;
        bus.abort     = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_steps = C'($urandom);
        bus.abort     = 1'b0;
        exp_ab        = 1'b0;
        ended         = 1'b0;
        for (int k = 1; k <= steps && !ended; k++) begin
            exp = {phase_val(pos), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            obs = observe();
            n_checks++;
            if (obs !== exp) $display("FAIL %s run k=%0d: {out,busy,rdy,done,abt,err}=%b want %b", name, k, obs, exp);
            else n_pass++;
            bus.abort   = (k == abort_k);
            bus.cmd_dir = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (k == abort_k) begin
                ended  = 1'b1;
                exp_ab = 1'b1;
            end else begin
                pos = dir ? (pos + PERIOD - 1) % PERIOD : (pos + 1) % PERIOD;
                if (k == steps) ended = 1'b1;
            end
            bus.abort = 1'b0;
        end
        exp = {phase_val(pos), 1'b0, 1'b0, 1'b1, exp_ab, 1'b0};
        obs = observe();
        n_checks++;
        if (obs !== exp) $display("FAIL %s done: {out,busy,rdy,done,abt,err}=%b want %b", name, obs, exp);
        else n_pass++;
        @(negedge clk);
        exp = {phase_val(pos), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        obs = observe();
        n_checks++;
        if (obs !== exp) $display("FAIL %s idle: {out,busy,rdy,done,abt,err}=%b want %b", name, obs, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [W+4:0] exp;
        exp  = {W'(0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (observe() !== exp) $display("FAIL reset_held: got %b want %b", observe(), exp);
        else n_pass++;
        rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (observe() !== exp) $display("FAIL reset_released: got %b want %b", observe(), exp);
        else n_pass++;
        pos = 0;
    endtask

    task automatic test_directed();
        do_cmd("fwd5", 5, 1'b0, 0);
        n_checks++;
        if (bus.out !== 4'b1110) $display("FAIL fwd5_final: out=%b want 1110", bus.out);
        else n_pass++;
        do_cmd("rev3", 3, 1'b1, 0);
        n_checks++;
        if (bus.out !== 4'b0011) $display("FAIL rev3_final: out=%b want 0011", bus.out);
        else n_pass++;
        do_cmd("wrap8", 8, 1'b0, 0);
        n_checks++;
        if (bus.out !== 4'b0011) $display("FAIL wrap8_final: out=%b want 0011", bus.out);
        else n_pass++;
        do_cmd("zero", 0, 1'b1, 0);
        do_cmd("abort4", 10, 1'b0, 4);
        n_checks++;
        if (bus.out !== 4'b1110) $display("FAIL abort4_final: out=%b want 1110", bus.out);
        else n_pass++;
        do_cmd("abort_last", 3, 1'b1, 3);
        n_checks++;
        if (bus.out !== 4'b0111) $display("FAIL abort_last_final: out=%b want 0111", bus.out);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        int start = pos;
        bus.cmd_valid = 1'b1;
        bus.cmd_steps = C'(2);
        bus.cmd_dir   = 1'b0;
        for (int j = 1; j <= 11; j++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
            n_checks++;
            if (bus.cmd_ready === 1'b1 && bus.busy === 1'b1) $display("FAIL b2b_ready_busy j=%0d: both high", j);
            else n_pass++;
            if (j == 11) bus.cmd_valid = 1'b0;
        end
        repeat (3) @(negedge clk);
        pos = (start + 6) % PERIOD;
        n_checks++;
        if (dones != 3) $display("FAIL b2b_done_count: got %0d want 3", dones);
        else n_pass++;
        n_checks++;
        if (bus.out !== phase_val(pos) || bus.cmd_ready !== 1'b1)
            $display("FAIL b2b_final: out=%b rdy=%b want out=%b rdy=1", bus.out, bus.cmd_ready, phase_val(pos));
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        logic [W+4:0] exp;
        bus.cmd_valid = 1'b1;
        bus.cmd_steps = C'(10);
        bus.cmd_dir   = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        exp = {W'(0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (observe() !== exp) $display("FAIL midrun_reset: got %b want %b", observe(), exp);
        else n_pass++;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        pos  = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_checks++;
            if (observe() !== exp) $display("FAIL midrun_after j=%0d: got %b want %b", j, observe(), exp);
            else n_pass++;
        end
    endtask

    task automatic test_illegal();
        logic [W+4:0] exp;
`ifdef JOHNSON_SELFCHECK_EN
        bus.cmd_valid = 1'b1;
        bus.cmd_steps = C'(10);
        bus.cmd_dir   = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        force dut.u_core.r_out = 4'b0101;
        #1;
        release dut.u_core.r_out;
        @(negedge clk);
        exp = {4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        n_checks++;
        if (observe() !== exp) $display("FAIL illegal_trap: got %b want %b", observe(), exp);
        else n_pass++;
        @(negedge clk);
        exp = {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (observe() !== exp) $display("FAIL illegal_recover: got %b want %b", observe(), exp);
        else n_pass++;
        pos = 0;
`else
        force dut.u_core.r_out = 4'b0101;
        #1;
        release dut.u_core.r_out;
        @(negedge clk);
        n_checks++;
        if (bus.out !== 4'b0101 || bus.err !== 1'b0) $display("FAIL illegal_hold: out=%b err=%b want 0101 0", bus.out, bus.err);
        else n_pass++;
        bus.cmd_valid = 1'b1;
        bus.cmd_steps = C'(1);
        bus.cmd_dir   = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        exp = {4'b1011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (observe() !== exp) $display("FAIL illegal_propagate: got %b want %b", observe(), exp);
        else n_pass++;
        @(negedge clk);
        test_reset();
`endif
    endtask

    task automatic test_random();
        int steps;
        int abort_k;
        for (int i = 0; i < 30; i++) begin
            steps   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 14));
            abort_k = ($urandom_range(0, 3) == 0 && steps > 0) ? int'($urandom_range(1, steps)) : 0;
            do_cmd("random", steps, 1'($urandom_range(0, 1)), abort_k);
        end
        do_cmd("random_long", 40, 1'b1, 0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_steps = '0;
        bus.cmd_dir   = 1'b0;
        bus.abort     = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_run();
        test_illegal();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/johnson_step_ctrl.md
# johnson_step_ctrl

Command-driven sequencer for a WIDTH-bit Johnson (twisted-ring) counter. Accepts step commands (count + direction) over a valid/ready handshake, advances the counter one state per clock until the count is exhausted or an abort arrives, then pulses `done`. Sits between a control/CSR master and any logic consuming the one-hot-decodable Johnson phase (phase generators, stepper drives).

## Interface
- `WIDTH`, 4: Johnson register width; period = 2*WIDTH states; legal WIDTH >= 2
- `CNT_W`, 8: width of the step-count field
- `clk`  in  1  clock, all logic on rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  controller can accept a command
- `cmd_steps`  in  CNT_W  number of steps to advance (0 allowed)
- `cmd_dir`  in  1  0 = forward, 1 = reverse
- `abort`  in  1  stop current run
- `out`  out  WIDTH  Johnson counter value
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle completion pulse
- `aborted`  out  1  valid with `done`; 1 = run ended by abort
- `err`  out  1  one-cycle illegal-state pulse (see Configuration)

## Operation
- Reset: `out`=0, state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `aborted`=0, `err`=0.
- Forward step: `out <= {out[WIDTH-2:0], ~out[WIDTH-1]}` (0000→0001→0011→0111→1111→1110→1100→1000→0000).
- Reverse step: `out <= {~out[0], out[WIDTH-1:1]}`; exact inverse of forward.
- FSM states IDLE, RUN, DONE:
  - IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`: latch `cmd_dir`; if `cmd_steps`==0 go DONE (aborted=0), else load remaining=`cmd_steps`, go RUN. `abort` ignored.
  - RUN: `cmd_ready`=0, `busy`=1. If `abort`: no step this cycle, `out` holds, go DONE with aborted=1. Else step `out`, remaining−1; when remaining==1 go DONE with aborted=0.
  - DONE: `done`=1, `aborted` valid, `cmd_ready`=0; unconditionally to IDLE.
- `abort` on the same cycle as the final step: abort wins; that step is not taken; aborted=1.
- `cmd_valid` outside IDLE is held off by `cmd_ready`=0; no queueing.
- `out` holds its value between commands (position persists); wrap-around is natural modulo 2*WIDTH.
- Remaining counter is CNT_W bits, no overflow possible (only decrements).
- `rstn` asserted mid-run: immediate return to reset values; no `done` issued.

## Timing
- Handshake at edge T: first `out` change at edge T+1; Nth step at edge T+N; `done` high in cycle after T+N; `cmd_ready` high again after edge T+N+1.
- Zero-step command at edge T: `done` high in cycle after T, `out` unchanged.
- Throughput: one command per N+2 cycles (N≥1), per 2 cycles for N=0.
- Abort sampled at edge T+k (k≥1): steps taken = k−1; `done` high in cycle after T+k.
- All outputs registered.

## Configuration
- `JOHNSON_SELFCHECK_EN` defined: each cycle `out` checked for legality (count of adjacent-bit differences over `out[WIDTH-1:0]` ≤ 1). Illegal value: next edge forces `out`=0 and pulses `err` one cycle; if in RUN, run terminates to DONE with aborted=1; check has priority over stepping and abort.
- Not defined: no checker, `err` tied 0, illegal states propagate unchanged.

## Structure
- Package `johnson_pkg`: FSM state enum (IDLE, RUN, DONE), direction constants `DIR_FWD`=0/`DIR_REV`=1.
- Sub-module `johnson_core`: WIDTH-bit register with `en`, `dir`, synchronous `clr`, asynchronous `rstn`, next-state logic, and (under macro) legality flag. Controller holds FSM, remaining count, handshake.

## Test plan
- Reset then cmd steps=5 dir=0 from 0000 → `out` 0001,0011,0111,1111,1110 on consecutive edges; `done`=1, `aborted`=0 one cycle later; `cmd_ready` back next cycle.
- From 1110 cmd steps=3 dir=1 → 1111,0111,0011; then steps=8 dir=0 → returns to 0011 (full period wrap).
- steps=0 → `done` next cycle, `out` unchanged, `busy` never high.
- steps=10, `abort` on 4th RUN cycle → exactly 3 steps taken, `done`=1, `aborted`=1; abort with final step → aborted=1, step not taken.
- `cmd_valid` held high throughout runs → second command accepted only in IDLE; `rstn` low mid-run → `out`=0, no `done`.
- With `JOHNSON_SELFCHECK_EN`, force core register to 0101 during RUN → `err` one pulse, `out`=0000, `done` with `aborted`=1; without macro `err` stays 0.
